// File: rtl/limits_stream_unit.sv
// limits_stream_unit: two-stage stream pipeline (shift/round, then clamp) with a per-frame
// saturation pulse. Defining LIMITS_SAT_COUNT_EN adds a saturating count of clamped channels.
module limits_stream_unit #(
    parameter int IN_W     = 9,
    parameter int OUT_W    = 8,
    parameter int CHANNELS = 2,
    parameter int SHIFT    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*IN_W-1:0]  s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic [CHANNELS*OUT_W-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    input  logic                      sym_i,
    output logic                      frame_sat_o,
    input  logic                      sat_clr_i,
    output logic [15:0]               sat_count_o
);
    localparam int RW    = IN_W + 1;
    localparam int MAX_I = (1 << (OUT_W - 1)) - 1;
    localparam logic signed [RW-1:0] MAX_V    = RW'(MAX_I);
    localparam logic signed [RW-1:0] MIN_ASYM = RW'(-MAX_I - 1);
    localparam logic signed [RW-1:0] MIN_SYM  = RW'(-MAX_I);

    logic                      en;
    logic                      m_fire;
    logic                      s1_valid_q;
    logic                      s1_last_q;
    logic [CHANNELS*RW-1:0]    s1_data_q;
    logic [CHANNELS*RW-1:0]    s1_data_d;
    logic [CHANNELS*OUT_W-1:0] s2_data_d;
    logic [CHANNELS-1:0]       s2_sat;
    logic signed [RW-1:0]      min_v;
    logic                      m_sat_q;
    logic                      frame_flag_q;

    assign en            = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = en;
    assign m_fire        = m_axis_tvalid && m_axis_tready;
    assign min_v         = sym_i ? MIN_SYM : MIN_ASYM;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic signed [RW-1:0] x_ext;
        logic signed [RW-1:0] r;
        logic signed [RW-1:0] r1;
        logic [OUT_W-1:0]     y;
        logic                 sat;

        assign x_ext = {s_axis_tdata[k*IN_W+IN_W-1], s_axis_tdata[k*IN_W +: IN_W]};

        if (SHIFT > 0) begin : g_rnd
            localparam logic signed [RW-1:0] HALF = RW'(2 ** (SHIFT - 1));
            logic signed [RW-1:0] sum;
            // One extra bit of headroom keeps the half-LSB add from overflowing.
            assign sum = x_ext + HALF;
            assign r   = sum >>> SHIFT;
        end else begin : g_nornd
            assign r = x_ext;
        end
        assign s1_data_d[k*RW +: RW] = r;

        assign r1 = s1_data_q[k*RW +: RW];
        always_comb begin
            sat = 1'b0;
            y   = r1[OUT_W-1:0];
            if (r1 > MAX_V) begin
                sat = 1'b1;
                y   = MAX_V[OUT_W-1:0];
            end else if (r1 < min_v) begin
                sat = 1'b1;
                y   = min_v[OUT_W-1:0];
            end
        end
        assign s2_data_d[k*OUT_W +: OUT_W] = y;
        assign s2_sat[k]                   = sat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_last_q     <= 1'b0;
            s1_data_q     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_sat_q       <= 1'b0;
        end else if (en) begin
            s1_valid_q    <= s_axis_tvalid;
            s1_last_q     <= s_axis_tlast;
            s1_data_q     <= s1_data_d;
            m_axis_tvalid <= s1_valid_q;
            m_axis_tlast  <= s1_last_q;
            m_axis_tdata  <= s2_data_d;
            m_sat_q       <= s1_valid_q && (|s2_sat);
        end
    end

    // The flag accumulates over handshaked beats; the tlast beat counts toward its own frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_flag_q <= 1'b0;
            frame_sat_o  <= 1'b0;
        end else begin
            frame_sat_o <= m_fire && m_axis_tlast && (frame_flag_q || m_sat_q);
            if (m_fire) begin
                frame_flag_q <= m_axis_tlast ? 1'b0 : (frame_flag_q || m_sat_q);
            end
        end
    end

`ifdef LIMITS_SAT_COUNT_EN
    localparam int CW = $clog2(CHANNELS + 1);

    logic [CW-1:0] beat_sat_n;
    logic [15:0]   sat_count_q;
    logic [16:0]   count_sum;

    always_comb begin
        beat_sat_n = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            beat_sat_n = beat_sat_n + CW'(s2_sat[k]);
        end
    end

    assign count_sum = {1'b0, sat_count_q} + 17'(beat_sat_n);

    always_ff @(posedge clk) begin
        if (rst || sat_clr_i) begin
            sat_count_q <= 16'h0;
        end else if (en && s1_valid_q) begin
            sat_count_q <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
        end
    end

    assign sat_count_o = sat_count_q;
`else
    logic unused_sat_clr;

    assign unused_sat_clr = sat_clr_i;
    assign sat_count_o    = 16'h0;
`endif

endmodule

// File: tb/tb_limits_stream_unit.sv
// tb_limits_stream_unit: random framed traffic with random back-pressure scored against an
// arithmetic model of the round/clamp/frame rules; second instance covers SHIFT=1.
module tb_limits_stream_unit;
    localparam int IN_W  = 9;
    localparam int OUT_W = 8;
    localparam int CH    = 2;
    localparam int DW    = CH * IN_W;
    localparam int OW    = CH * OUT_W;

    typedef struct {
        logic [OW-1:0] data;
        logic          last;
        int            nsat;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic [OW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          sym;
    logic          frame_sat;
    logic          sat_clr;
    logic [15:0]   sat_count;

    logic [DW-1:0] b_s_data;
    logic          b_s_valid;
    logic          b_s_ready;
    logic [OW-1:0] b_m_data;
    logic          b_m_valid;
    logic          b_m_last;
    logic          b_frame_sat;
    logic [15:0]   b_sat_count;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic acc, exp_pulse, lat_chk;
    logic prev_stall, prev_last;
    logic [OW-1:0] prev_data;
    int   cnt_a, cnt_b, frame_left;
    logic hot;
    logic [DW-1:0] dq[$];

    always #5 clk = ~clk;

    limits_stream_unit u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_data),
        .s_axis_tvalid (s_valid),
        .s_axis_tready (s_ready),
        .s_axis_tlast  (s_last),
        .m_axis_tdata  (m_data),
        .m_axis_tvalid (m_valid),
        .m_axis_tready (m_ready),
        .m_axis_tlast  (m_last),
        .sym_i         (sym),
        .frame_sat_o   (frame_sat),
        .sat_clr_i     (sat_clr),
        .sat_count_o   (sat_count)
    );

    limits_stream_unit #(.SHIFT(1)) u_dut_b (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (b_s_data),
        .s_axis_tvalid (b_s_valid),
        .s_axis_tready (b_s_ready),
        .s_axis_tlast  (1'b0),
        .m_axis_tdata  (b_m_data),
        .m_axis_tvalid (b_m_valid),
        .m_axis_tready (1'b1),
        .m_axis_tlast  (b_m_last),
        .sym_i         (1'b0),
        .frame_sat_o   (b_frame_sat),
        .sat_clr_i     (1'b0),
        .sat_count_o   (b_sat_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Rounded shift then clamp, in plain integer arithmetic.
    function automatic void model_beat(input logic [DW-1:0] d, input int sh, input logic sy,
                                       output logic [OW-1:0] o, output int nsat);
        int maxv, minv, x, r;
        maxv = (1 << (OUT_W - 1)) - 1;
        minv = sy ? -maxv : -maxv - 1;
        nsat = 0;
        o    = '0;
        for (int k = 0; k < CH; k++) begin
            x = int'($signed(d[k*IN_W +: IN_W]));
            r = x;
            if (sh > 0) r = (x + (1 << (sh - 1))) >>> sh;
            if (r > maxv) begin
                r = maxv;
                nsat++;
            end else if (r < minv) begin
                r = minv;
                nsat++;
            end
            o[k*OUT_W +: OUT_W] = r[OUT_W-1:0];
        end
    endfunction

    function automatic int sat_add(input int c, input int n);
        return (c + n > 65535) ? 65535 : c + n;
    endfunction

    function automatic int exp_count(input int c);
`ifdef LIMITS_SAT_COUNT_EN
        return c;
`else
        return 0 * c;
`endif
    endfunction

    task automatic cycle(output logic fired);
        exp_t e;
        logic [OW-1:0] o;
        int ns;
        logic due;
        @(negedge clk);
        cyc++;
        fired = 1'b0;
        if (rst) begin
            q_a.delete();
            q_b.delete();
            acc = 0; exp_pulse = 0; cnt_a = 0; cnt_b = 0; prev_stall = 0;
        end else begin
            check("s_ready_rule", s_ready, !m_valid || m_ready);
            check("frame_sat", frame_sat, exp_pulse);
            if (prev_stall) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, prev_data);
                check("stall_last", m_last, prev_last);
            end
            if (lat_chk) begin
                due = 1'b0;
                if (q_a.size() > 0) due = (cyc - q_a[0].cyc == 2);
                check("a_valid_latency", m_valid, due);
            end
            exp_pulse = 1'b0;
            if (m_valid && m_ready) begin
                if (q_a.size() == 0) begin
                    check("a_extra_beat", m_valid, 0);
                end else begin
                    e = q_a.pop_front();
                    check("a_data", m_data, e.data);
                    check("a_last", m_last, e.last);
                    acc = acc || (e.nsat > 0);
                    if (e.last) begin
                        exp_pulse = acc;
                        acc = 1'b0;
                    end
                end
            end
            if (s_valid && s_ready) begin
                fired = 1'b1;
                model_beat(s_data, 0, sym, o, ns);
                q_a.push_back('{data: o, last: s_last, nsat: ns, cyc: cyc});
                cnt_a = sat_add(cnt_a, ns);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;

            check("b_ready", b_s_ready, 1);
            check("b_frame_sat", b_frame_sat, 0);
            check("b_last", b_m_last, 0);
            due = 1'b0;
            if (q_b.size() > 0) due = (cyc - q_b[0].cyc == 2);
            check("b_valid_latency", b_m_valid, due);
            if (b_m_valid && q_b.size() > 0) begin
                e = q_b.pop_front();
                check("b_data", b_m_data, e.data);
            end
            if (b_s_valid) begin
                model_beat(b_s_data, 1, 1'b0, o, ns);
                q_b.push_back('{data: o, last: 1'b0, nsat: ns, cyc: cyc});
                cnt_b = sat_add(cnt_b, ns);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gen_beat();
        logic [IN_W-1:0] v;
        if (frame_left == 0) begin
            frame_left = $urandom_range(1, 5);
            hot = ($urandom_range(0, 1) == 1);
        end
        if (dq.size() > 0) begin
            s_data = dq.pop_front();
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (hot) v = IN_W'($urandom);
                else v = IN_W'($urandom_range(0, 254) - 127);
                s_data[k*IN_W +: IN_W] = v;
            end
        end
        s_last = (frame_left == 1);
        frame_left--;
    endtask

    task automatic run_a(input int n, input int ready_pct);
        logic f;
        for (int i = 0; i < n; i++) begin
            m_ready = ($urandom_range(0, 99) < ready_pct);
            if (!s_valid && $urandom_range(0, 3) != 0) begin
                gen_beat();
                s_valid = 1'b1;
            end
            b_s_valid = ($urandom_range(0, 1) == 1);
            b_s_data  = DW'($urandom);
            if (cyc < 8) b_s_data = (cyc[0]) ? {9'h000, 9'h1FD} : {9'h000, 9'h003};
            cycle(f);
            if (f) s_valid = 1'b0;
        end
    endtask

    task automatic drain();
        logic f;
        int guard;
        guard = 0;
        m_ready   = 1'b1;
        b_s_valid = 1'b0;
        while (s_valid && guard < 50) begin
            cycle(f);
            if (f) s_valid = 1'b0;
            guard++;
        end
        check("drain_accepted", s_valid, 0);
        repeat (3) cycle(f);
        check("a_queue_empty", q_a.size(), 0);
        check("b_queue_empty", q_b.size(), 0);
        check("sat_count", sat_count, exp_count(cnt_a));
        check("b_sat_count", b_sat_count, exp_count(cnt_b));
    endtask

    initial begin
        logic f;
        rst = 1'b1; s_data = '0; s_valid = 0; s_last = 0; m_ready = 0; sym = 0; sat_clr = 0;
        b_s_data = '0; b_s_valid = 0; lat_chk = 0; frame_left = 0; hot = 0;
        acc = 0; exp_pulse = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
        cnt_a = 0; cnt_b = 0;
        repeat (2) cycle(f);
        rst = 1'b0;
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        check("rst_frame_sat", frame_sat, 0);
        check("rst_sat_count", sat_count, 0);
        check("rst_s_ready", s_ready, 1);

        // Unstalled traffic, then random back-pressure, for both clamp modes.
        dq.push_back({9'h100, 9'h0FF});
        lat_chk = 1;
        run_a(200, 100);
        drain();
        lat_chk = 0;
        run_a(600, 70);
        drain();
        sym = 1'b1;
        dq.push_back({9'h180, 9'h000});
        dq.push_back({9'h181, 9'h000});
        lat_chk = 1;
        run_a(200, 100);
        drain();
        lat_chk = 0;
        run_a(600, 60);
        drain();
        sym = 1'b0;
        run_a(300, 30);

        // Reset with beats in flight.
        m_ready = 1'b0;
        s_valid = 1'b0;
        s_data  = {9'h100, 9'h0FF};
        s_last  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            cycle(f);
        end
        s_valid = 1'b0;
        rst = 1'b1;
        cycle(f);
        rst = 1'b0;
        frame_left = 0;
        check("midrst_m_valid", m_valid, 0);
        check("midrst_s_ready", s_ready, 1);
        check("midrst_count", sat_count, 0);
        lat_chk = 1;
        run_a(200, 100);
        drain();

        // Counter saturation and clear-over-increment.
        s_data  = {9'h100, 9'h0FF};
        s_last  = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 32768; i++) cycle(f);
        s_valid = 1'b0;
        drain();
        check("count_at_max", sat_count, exp_count(65535));
        s_valid = 1'b1;
        s_last  = 1'b1;
        cycle(f);
        s_valid = 1'b0;
        drain();
        check("count_stays_max", sat_count, exp_count(65535));
        s_valid = 1'b1;
        s_last  = 1'b0;
        cycle(f);
        s_valid = 1'b0;
        sat_clr = 1'b1;
        cycle(f);
        sat_clr = 1'b0;
        cnt_a = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/limits_stream_unit.md
LIMITS_STREAM_UNIT -- requirements
Module: limits_stream_unit

Interface
REQ-001 SHALL have parameter IN_W, default 9, signed input sample width per channel.
REQ-002 SHALL have parameter OUT_W, default 8, signed output sample width per channel, OUT_W <= IN_W.
REQ-003 SHALL have parameter CHANNELS, default 2, samples per beat (re/im); channel k at bits [k*W +: W].
REQ-004 SHALL have parameter SHIFT, default 0, arithmetic right-shift applied before saturation, 0 <= SHIFT < IN_W.
REQ-005 SHALL have ports: clk  in  1  clock, single domain; rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: s_axis_tdata  in  CHANNELS*IN_W, s_axis_tvalid  in  1, s_axis_tready  out  1, s_axis_tlast  in  1 (input stream).
REQ-007 SHALL have ports: m_axis_tdata  out  CHANNELS*OUT_W, m_axis_tvalid  out  1, m_axis_tready  in  1, m_axis_tlast  out  1 (output stream).
REQ-008 SHALL have ports: sym_i  in  1  symmetric clamp select; frame_sat_o  out  1  per-frame saturation pulse; sat_clr_i  in  1  counter clear; sat_count_o  out  16  saturation count.

Function
REQ-009 SHALL be a 2-stage registered pipeline: S1 shift/round, S2 saturate, S2 register drives m_axis.
REQ-010 SHALL advance both stages when en = !m_axis_tvalid || m_axis_tready; s_axis_tready = en (combinational).
REQ-011 SHALL present an accepted beat on m_axis 2 cycles after its s_axis handshake when unstalled; throughput 1 beat/cycle.
REQ-012 SHALL hold m_axis_tdata/tlast/tvalid stable while m_axis_tvalid=1 and m_axis_tready=0; no beat lost or duplicated.
REQ-013 SHALL propagate tlast alongside its beat through both stages.
REQ-014 S1 SHALL compute r = (x + 2^(SHIFT-1)) >>> SHIFT at IN_W+1 bits (round half up) when SHIFT>0; r = x sign-extended when SHIFT=0.
REQ-015 S2 SHALL clamp r to MAX = 2^(OUT_W-1)-1 and MIN = -2^(OUT_W-1) when sym_i=0, MIN = -(2^(OUT_W-1)-1) when sym_i=1.
REQ-016 S2 SHALL pass r[OUT_W-1:0] unchanged when MIN <= r <= MAX; each channel independent.
REQ-017 sym_i SHALL be sampled at S2 advance; changes affect beats entering S2 thereafter.
REQ-018 SHALL flag a channel saturated when clamping altered its value.
REQ-019 frame_sat_o SHALL pulse 1 cycle, the cycle after the m_axis tlast handshake, iff any channel of any beat of that frame saturated; frame flag then clears.
REQ-020 A saturated tlast beat SHALL count toward its own frame; next frame starts clean.

Reset
REQ-021 On rst=1 at clk edge: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, both stage valids=0, frame flag=0, frame_sat_o=0, sat_count_o=0.
REQ-022 Reset mid-frame SHALL drop all in-flight beats and the partial frame flag; s_axis_tready=1 in first cycle after reset release.

Configuration
REQ-023 Macro LIMITS_SAT_COUNT_EN defined: sat_count_o counts saturated channels per S2 advance (0..CHANNELS per beat), saturating at 16'hFFFF.
REQ-024 With LIMITS_SAT_COUNT_EN: sat_clr_i=1 zeroes counter next edge; clear wins over simultaneous increment.
REQ-025 Without LIMITS_SAT_COUNT_EN: sat_count_o tied 0, sat_clr_i ignored, no counter logic synthesised; all other behaviour identical.

Verification
REQ-026 Defaults, sym_i=0, beat re=9'h0FF (255), im=9'h100 (-256), m_tready=1 -> 2 cycles later tdata re=8'h7F, im=8'h80; count +2.
REQ-027 Defaults, sym_i=1, im=9'h180 (-128) -> im=8'h81 (-127), count +1; im=9'h181 (-127) -> 8'h81, no saturation.
REQ-028 SHIFT=1, IN_W=9, re=9'h003 -> 8'h02; re=9'h1FD (-3) -> 8'hFF (-1).
REQ-029 4-beat frame, m_tready low 3 cycles mid-frame, one beat saturating -> s_tready low during stall, 4 beats in order, tlast on 4th, frame_sat_o 1 pulse after tlast handshake; clean frame after -> no pulse.
REQ-030 rst asserted with 2 beats in flight -> m_tvalid=0 next cycle, no beats emitted, count=0; counter at 16'hFFFF plus saturating beat -> stays FFFF; sat_clr_i with increment -> 0.
